// File: rtl/matmul_pkg.sv
// Shared definitions for the fixed-point matrix-multiply engine: FSM encoding,
// tensor identifiers, accumulator sizing and saturation limits.
package matmul_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_MAC   = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [1:0] TENSOR_C = 2'd0;
  localparam logic [1:0] TENSOR_A = 2'd1;
  localparam logic [1:0] TENSOR_B = 2'd2;

  // Wide enough for K full products plus a pre-loaded, pre-shifted C value.
  function automatic int acc_width(input int width, input int k);
    return 2 * width + $clog2(k + 1) + 1;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate datapath with an output stage that rescales the
// accumulator by FRAC bits (floor) and clamps it to the element range.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int K     = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic signed [WIDTH-1:0] i_load_val,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_result,
  output logic                    o_sat_hit
);

  localparam int ACC_W = acc_width(WIDTH, K);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(WIDTH));

  logic signed [ACC_W-1:0]   r_acc;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_load_ext;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_hi;
  logic                      w_lo;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  // A pre-loaded C element is brought into the product's fixed-point scale.
  assign w_load_ext = {{(ACC_W-WIDTH){i_load_val[WIDTH-1]}}, i_load_val} <<< FRAC;
  assign w_shift    = r_acc >>> FRAC;
  assign w_hi       = (w_shift > SAT_HI);
  assign w_lo       = (w_shift < SAT_LO);
  assign o_sat_hit  = w_hi | w_lo;
  assign o_result   = w_hi ? SAT_HI[WIDTH-1:0] :
                      w_lo ? SAT_LO[WIDTH-1:0] : w_shift[WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_load_ext;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Fixed-point C = A x B (or C += A x B) engine over three on-chip tensor
// memories, with a host write/read port and a start/busy/done handshake.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int M     = 2,
  parameter int K     = 3,
  parameter int N     = 2,
  parameter int IDX_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_accumulate,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sat,
  input  logic             i_wr_en,
  input  logic [1:0]       i_wr_tensor,
  input  logic [IDX_W-1:0] i_wr_index,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [1:0]       i_rd_tensor,
  input  logic [IDX_W-1:0] i_rd_index,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int SZ_A = M * K;
  localparam int SZ_B = K * N;
  localparam int SZ_C = M * N;
  localparam int AW_A = (SZ_A > 1) ? $clog2(SZ_A) : 1;
  localparam int AW_B = (SZ_B > 1) ? $clog2(SZ_B) : 1;
  localparam int AW_C = (SZ_C > 1) ? $clog2(SZ_C) : 1;
  localparam logic [IDX_W-1:0] L_SZ_A = IDX_W'(SZ_A);
  localparam logic [IDX_W-1:0] L_SZ_B = IDX_W'(SZ_B);
  localparam logic [IDX_W-1:0] L_SZ_C = IDX_W'(SZ_C);
  localparam logic [IDX_W-1:0] L_K    = IDX_W'(K);
  localparam logic [IDX_W-1:0] L_N    = IDX_W'(N);
  localparam logic [IDX_W-1:0] M_LAST = IDX_W'(M - 1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K - 1);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N - 1);

  logic [WIDTH-1:0] r_mem_a [SZ_A];
  logic [WIDTH-1:0] r_mem_b [SZ_B];
  logic [WIDTH-1:0] r_mem_c [SZ_C];

  state_t           r_state;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_k;
  logic             r_mode;
  logic             r_sat;

  logic [AW_A-1:0]  w_a_addr;
  logic [AW_B-1:0]  w_b_addr;
  logic [AW_C-1:0]  w_c_addr;
  logic             w_host_wr;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_result;
  logic             w_sat_hit;

  assign w_a_addr   = AW_A'(r_i * L_K + r_k);
  assign w_b_addr   = AW_B'(r_k * L_N + r_j);
  assign w_c_addr   = AW_C'(r_i * L_N + r_j);
  assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_MAC) || (r_state == ST_WRITE);
  assign o_done     = (r_state == ST_DONE);
  assign o_sat      = r_sat;
  assign w_host_wr  = i_wr_en && !o_busy;
  assign w_load_val = r_mode ? r_mem_c[w_c_addr] : '0;

  matmul_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .K(K)) u_mac (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (r_state == ST_LOAD),
    .i_load_val (w_load_val),
    .i_en       (r_state == ST_MAC),
    .i_a        (r_mem_a[w_a_addr]),
    .i_b        (r_mem_b[w_b_addr]),
    .o_result   (w_result),
    .o_sat_hit  (w_sat_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mode  <= i_accumulate;
            r_sat   <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_k     <= '0;
          r_state <= ST_MAC;
        end
        ST_MAC: begin
          if (r_k == K_LAST) r_state <= ST_WRITE;
          else               r_k     <= r_k + 1'b1;
        end
        ST_WRITE: begin
          if (w_sat_hit) r_sat <= 1'b1;
          // Row-major walk: j is the inner loop.
          if (r_i == M_LAST && r_j == N_LAST) begin
            r_state <= ST_DONE;
          end else begin
            if (r_j == N_LAST) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
            r_state <= ST_LOAD;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memories carry no reset; host and kernel writes never coincide.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_WRITE) begin
      r_mem_c[w_c_addr] <= w_result;
    end else if (w_host_wr && i_wr_tensor == TENSOR_C && i_wr_index < L_SZ_C) begin
      r_mem_c[AW_C'(i_wr_index)] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_host_wr && i_wr_tensor == TENSOR_A && i_wr_index < L_SZ_A)
      r_mem_a[AW_A'(i_wr_index)] <= i_wr_data;
    if (w_host_wr && i_wr_tensor == TENSOR_B && i_wr_index < L_SZ_B)
      r_mem_b[AW_B'(i_wr_index)] <= i_wr_data;
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_tensor)
      TENSOR_C: if (i_rd_index < L_SZ_C) o_rd_data = r_mem_c[AW_C'(i_rd_index)];
      TENSOR_A: if (i_rd_index < L_SZ_A) o_rd_data = r_mem_a[AW_A'(i_rd_index)];
      TENSOR_B: if (i_rd_index < L_SZ_B) o_rd_data = r_mem_b[AW_B'(i_rd_index)];
      default:  o_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed and randomized bench for matmul_engine, checked against an
// arithmetic model of the 2x3x2 Q8.8 kernel.
module tb_matmul_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        accumulate;
  logic        busy;
  logic        done;
  logic        sat;
  logic        wr_en;
  logic [1:0]  wr_tensor;
  logic [15:0] wr_index;
  logic [15:0] wr_data;
  logic [1:0]  rd_tensor;
  logic [15:0] rd_index;
  logic [15:0] rd_data;

  logic [15:0] ma [6];
  logic [15:0] mb [6];
  logic [15:0] mc [4];
  logic        model_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_engine dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_accumulate (accumulate),
    .o_busy       (busy),
    .o_done       (done),
    .o_sat        (sat),
    .i_wr_en      (wr_en),
    .i_wr_tensor  (wr_tensor),
    .i_wr_index   (wr_index),
    .i_wr_data    (wr_data),
    .i_rd_tensor  (rd_tensor),
    .i_rd_index   (rd_index),
    .o_rd_data    (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host write; the model follows only writes the engine is required to accept.
  task automatic host_write(input logic [1:0] t, input int idx, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_tensor = t; wr_index = 16'(idx); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (t == 2'd1 && idx < 6) ma[idx] = d;
    if (t == 2'd2 && idx < 6) mb[idx] = d;
    if (t == 2'd0 && idx < 4) mc[idx] = d;
  endtask

  task automatic load_all(input logic [15:0] a_v [6], input logic [15:0] b_v [6]);
    for (int x = 0; x < 6; x++) host_write(2'd1, x, a_v[x]);
    for (int x = 0; x < 6; x++) host_write(2'd2, x, b_v[x]);
  endtask

  // C = floor((acc_mode ? C*2^8 : 0) + sum A*B) / 2^8, clamped to int16.
  task automatic model_run(input logic acc_mode);
    longint s;
    longint r;
    model_sat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = acc_mode ? longint'($signed(mc[i*2+j])) * 256 : 0;
        for (int k = 0; k < 3; k++)
          s += longint'($signed(ma[i*3+k])) * longint'($signed(mb[k*2+j]));
        r = s >>> 8;
        if (r > 32767) begin r = 32767; model_sat = 1'b1; end
        else if (r < -32768) begin r = -32768; model_sat = 1'b1; end
        mc[i*2+j] = r[15:0];
      end
    end
  endtask

  task automatic check_c(input string name);
    for (int x = 0; x < 4; x++) begin
      rd_tensor = 2'd0; rd_index = 16'(x);
      #1;
      check($sformatf("%s C[%0d]", name, x), 32'(rd_data), 32'(mc[x]));
    end
  endtask

  // inject: 0 plain, 1 ignored write+start while busy and start in DONE, 2 reset at cycle 10
  task automatic run_kernel(input logic acc, input int inject, input string name);
    int cyc;
    int done_cyc;
    @(negedge clk); start = 1'b1; accumulate = acc;
    @(negedge clk); start = 1'b0; accumulate = 1'b0;
    cyc = 1; done_cyc = 0;
    while (cyc <= 60) begin
      if (done) begin done_cyc = cyc; break; end
      check($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'd1);
      if (inject == 1 && cyc == 5) begin
        wr_en = 1'b1; wr_tensor = 2'd1; wr_index = 16'd0; wr_data = 16'h1234;
        start = 1'b1; accumulate = 1'b1;
      end
      if (inject == 1 && cyc == 6) begin
        wr_en = 1'b0; start = 1'b0; accumulate = 1'b0;
      end
      if (inject == 2 && cyc == 10) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s rst busy", name), 32'(busy), 32'd0);
        check($sformatf("%s rst done", name), 32'(done), 32'd0);
        check($sformatf("%s rst sat", name), 32'(sat), 32'd0);
        @(negedge clk);
        check($sformatf("%s rst held idle", name), 32'(busy), 32'd0);
        rst_n = 1'b1;
        $display("run %s aborted by reset at cycle %0d", name, cyc);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s done cycle", name), 32'(done_cyc), 32'd21);
    check($sformatf("%s busy in done", name), 32'(busy), 32'd0);
    if (inject == 1) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s done pulse width", name), 32'(done), 32'd0);
    if (inject == 1) begin
      @(negedge clk);
      check($sformatf("%s start in done ignored", name), 32'(busy), 32'd0);
    end
    model_run(acc);
    check($sformatf("%s sat", name), 32'(sat), 32'(model_sat));
    check_c(name);
    $display("run %s acc=%0d done_cycle=%0d sat=%0d", name, acc, done_cyc, sat);
  endtask

  initial begin
    logic [15:0] seq [6];
    logic [15:0] zero [6];
    logic [15:0] ra [6];
    logic [15:0] rb [6];
    logic        racc;

    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; wr_en = 1'b0;
    wr_tensor = 2'd0; wr_index = 16'd0; wr_data = 16'd0;
    rd_tensor = 2'd0; rd_index = 16'd0;
    for (int x = 0; x < 6; x++) begin
      seq[x]  = 16'((x + 1) * 256);
      zero[x] = 16'd0;
    end

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sat", 32'(sat), 32'd0);
    rst_n = 1'b1;

    // A = B = 1..6
    load_all(seq, seq);
    rd_tensor = 2'd1; rd_index = 16'd5; #1;
    check("readback A[5]", 32'(rd_data), 32'h0600);
    rd_tensor = 2'd2; rd_index = 16'd2; #1;
    check("readback B[2]", 32'(rd_data), 32'h0300);
    run_kernel(1'b0, 0, "basic");
    rd_tensor = 2'd0; rd_index = 16'd3; #1;
    check("basic C[3] literal", 32'(rd_data), 32'h4000);
    run_kernel(1'b1, 0, "accum");
    rd_tensor = 2'd0; rd_index = 16'd3; #1;
    check("accum C[3] literal", 32'(rd_data), 32'h7FFF);
    check("accum sat literal", 32'(sat), 32'd1);

    // Saturation both directions
    load_all(zero, zero);
    for (int x = 0; x < 3; x++) host_write(2'd1, x, 16'h7F00);
    for (int x = 0; x < 3; x++) host_write(2'd2, x * 2, 16'h7F00);
    run_kernel(1'b0, 0, "sat_pos");
    rd_tensor = 2'd0; rd_index = 16'd0; #1;
    check("sat_pos C[0] literal", 32'(rd_data), 32'h7FFF);
    for (int x = 0; x < 3; x++) host_write(2'd2, x * 2, 16'h8100);
    run_kernel(1'b0, 0, "sat_neg");
    rd_tensor = 2'd0; rd_index = 16'd0; #1;
    check("sat_neg C[0] literal", 32'(rd_data), 32'h8000);

    // Fractional rounding toward -inf
    load_all(zero, zero);
    host_write(2'd1, 0, 16'hFF80);
    host_write(2'd2, 0, 16'h0080);
    run_kernel(1'b0, 0, "frac_exact");
    rd_tensor = 2'd0; rd_index = 16'd0; #1;
    check("frac_exact C[0] literal", 32'(rd_data), 32'hFFC0);
    host_write(2'd1, 0, 16'hFFFF);
    host_write(2'd2, 0, 16'h0001);
    run_kernel(1'b0, 0, "frac_floor");
    rd_tensor = 2'd0; rd_index = 16'd0; #1;
    check("frac_floor C[0] literal", 32'(rd_data), 32'hFFFF);

    // Writes and start while busy, start during DONE
    load_all(seq, seq);
    run_kernel(1'b0, 1, "midrun");
    rd_tensor = 2'd1; rd_index = 16'd0; #1;
    check("midrun A[0] untouched", 32'(rd_data), 32'h0100);

    // Reset mid-run, then a clean run
    run_kernel(1'b0, 2, "abort");
    run_kernel(1'b0, 0, "restart");

    // Randomized operands
    for (int t = 0; t < 5; t++) begin
      for (int x = 0; x < 6; x++) begin
        ra[x] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
        rb[x] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      end
      load_all(ra, rb);
      for (int x = 0; x < 4; x++) host_write(2'd0, x, 16'($urandom_range(0, 4095)) - 16'd2048);
      racc = 1'($urandom_range(0, 1));
      run_kernel(racc, 0, $sformatf("rand%0d", t));
    end

    // Out-of-range and ignored accesses
    rd_tensor = 2'd3; rd_index = 16'd0; #1;
    check("rd tensor3", 32'(rd_data), 32'd0);
    rd_tensor = 2'd0; rd_index = 16'd6; #1;
    check("rd C idx6", 32'(rd_data), 32'd0);
    rd_tensor = 2'd1; rd_index = 16'd6; #1;
    check("rd A idx6", 32'(rd_data), 32'd0);
    host_write(2'd0, 6, 16'hBEEF);
    host_write(2'd3, 0, 16'hBEEF);
    check_c("oor write");
    host_write(2'd0, 1, 16'h1111);
    check_c("idle C write");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised fixed-point matrix-multiply engine: computes C = A × B (A is M×K, B is K×N, C is M×N, row-major, signed Q(WIDTH−FRAC).FRAC) from on-chip tensor memories. Host loads A/B through a write port, starts the kernel with a one-cycle pulse, waits for `done`, then reads C through a combinational read port. It replaces the fixed 2×3×2, ROM-initialised kernel with one that has runtime-loadable operands, a wide accumulator, saturation, an accumulate mode and a busy/done handshake. It sits between the button/LED front end and the tensor memories.

## Interface
- WIDTH, 16, element width in bits (signed)
- FRAC, 8, fraction bits; 0 ≤ FRAC < WIDTH
- M, 2, rows of A and C
- K, 3, columns of A / rows of B; ≥ 1
- N, 2, columns of B and C
- IDX_W, 16, index width of host ports
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start request, sampled only in IDLE
- accumulate  in  1  sampled with `start`: 1 = C += A×B, 0 = C = A×B
- busy  out  1  kernel running
- done  out  1  one-cycle completion pulse
- sat  out  1  sticky: some C element saturated in the last run
- wr_en  in  1  host write strobe
- wr_tensor  in  2  0 = C, 1 = A, 2 = B, 3 = ignored
- wr_index  in  IDX_W  element index (row-major)
- wr_data  in  WIDTH  element value
- rd_tensor  in  2  0 = C, 1 = A, 2 = B, 3 → reads 0
- rd_index  in  IDX_W  element index
- rd_data  out  WIDTH  combinational read of selected element; 0 if index out of range

## Operation
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE: `start`=1 → latch `accumulate`, clear `sat`, i=j=0 → LOAD.
- LOAD: acc ← accumulate ? sign-extend(C[i·N+j]) << FRAC : 0; k=0 → MAC.
- MAC: acc ← acc + A[i·K+k] × B[k·N+j] (full 2·WIDTH-bit signed product, no per-term shift); k=K−1 → WRITE, else k++.
- WRITE: r = acc >>> FRAC (arithmetic, truncation toward −∞); clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; clamp taken → sat ← 1; C[i·N+j] ← r. Loop order: i outer, j inner. Last (i=M−1, j=N−1) → DONE, else advance → LOAD.
- DONE: done=1 for one cycle → IDLE.
- Accumulator width: 2·WIDTH + ceil(log2(K+1)) + 1 bits; never overflows internally.
- busy = 1 in LOAD/MAC/WRITE; 0 in IDLE and DONE.
- Host writes accepted only when busy=0; ignored while busy. Out-of-range wr_index ignored.
- Reads permitted any time; during a run they return current memory contents (partial C).
- `start` outside IDLE ignored (no queueing).
- Memories not cleared by reset; contents undefined until written.

## Timing
- Reset values: busy=0, done=0, sat=0, FSM=IDLE, indices 0. Reset mid-run aborts immediately; C partially written, no done pulse.
- Start sampled on edge t → busy=1 from t+1. Per C element K+2 cycles; done high in cycle t+1+M·N·(K+2); busy low in that same cycle.
- Default parameters: 20 busy cycles, done in 21st cycle after start edge.
- Host write visible on rd_data the cycle after the write edge.
- A `start` in the DONE cycle is ignored; earliest restart is the following IDLE cycle.

## Structure
- Package `matmul_pkg`: FSM state enum; tensor-id constants (TENSOR_C=0, TENSOR_A=1, TENSOR_B=2); accumulator-width and saturation helper functions.
- Sub-module `matmul_mac`: signed multiplier + accumulator + shift/saturate stage (inputs: clear/load value, a, b, enable; outputs: result, sat_hit). FSM, index counters and three memories stay in `matmul_engine`.

## Test plan
- A=B=[1,2,3,4,5,6] (Q8.8: 0x0100…0x0600), accumulate=0, start → done at cycle 21; C = 0x1600, 0x1C00, 0x3100, 0x4000; sat=0.
- Repeat same run with accumulate=1 → C = 0x2C00, 0x3800, 0x6200, 0x8000→saturated 0x7FFF; sat=1.
- A row 0 = 0x7F00 ×3, B column 0 = 0x7F00 ×3, others 0 → C[0]=0x7FFF, sat=1; with B column 0 = 0x8100 (−127) → C[0]=0x8000.
- A[0]=0xFF80 (−0.5), B[0]=0x0080 (0.5), rest 0 → C[0]=0xFFC0 (−0.25) exact; A[0]=0xFFFF, B[0]=0x0001 → C[0]=0xFFFF (floor).
- Mid-run: wr_en to A and second `start` while busy → both ignored, results as first test; reset_n low at cycle 10 → busy/done/sat 0 immediately, FSM IDLE, fresh start completes normally.
- Read rd_tensor=3 or rd_index=6 on C → rd_data=0; write wr_index=6 → no memory change.
